imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Hardware program loader for the pipelined RISC-V CPU. It is the writer side of instruction-memory initialisation and CPU start-up.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory.
- Zero-fills the unused remainder of instruction memory, then asserts the CPU start signal.
- Sits between an external byte source (UART receiver or bench) and the CPU's Instruction_Memory write port and start_i input.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory.
- ADDR_W, 8, word-address width; equals clog2(IMEM_DEPTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_valid_i  in  1  byte-stream valid.
- rx_data_i  in  8  stream byte.
- rx_ready_o  out  1  loader can accept a byte.
- imem_we_o  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr_o  out  ADDR_W  word address.
- imem_data_o  out  32  write data.
- cpu_start_o  out  1  drives CPU start_i; held high once the load completes.
- busy_o  out  1  load in progress.
- err_o  out  1  sticky error.

Behaviour:
- Reset values: all registered outputs are 0 (imem_we_o, imem_addr_o, imem_data_o, cpu_start_o, err_o). After reset the state is HDR0, so rx_ready_o = 1 and busy_o = 1.
- Reset asserted at any time, including mid-load, takes effect immediately. Partial words and counters are discarded.
- Handshake: a byte transfers on a rising edge where rx_valid_i && rx_ready_o. rx_data_i is ignored otherwise. rx_ready_o is a combinational decode of state: 1 in HDR0, HDR1, PAYLOAD and CKSUM; 0 in all other states.
- Stream format:
  - Byte 0 = word count N[7:0]; byte 1 = N[15:8].
  - Then N words of 4 bytes each, least-significant byte first.
  - Then, only when the checksum feature is enabled, one checksum byte.
- HDR0 -> HDR1 on an accepted byte.
- HDR1, on an accepted byte:
  - N > IMEM_DEPTH -> ERR.
  - N == 0 -> FILL.
  - Otherwise -> PAYLOAD.
- PAYLOAD:
  - A byte counter (0..3) shifts bytes into the word register.
  - On the 4th accepted byte of a word, the next cycle drives imem_we_o = 1, imem_addr_o = word index, imem_data_o = assembled word.
  - Byte acceptance continues uninterrupted; a stream with no gaps sustains 1 byte/cycle.
  - After word N-1 -> CKSUM if the feature is enabled, else FILL.
- FILL:
  - Writes 32'h0 to addresses N .. IMEM_DEPTH-1, one per cycle, with imem_we_o = 1.
  - The fill counter is ADDR_W+1 bits wide, so N == IMEM_DEPTH is handled: zero fill writes, direct to DONE.
- DONE:
  - cpu_start_o = 1 (registered, asserted the cycle after the last write).
  - busy_o = 0, rx_ready_o = 0.
  - Stays in DONE until reset.
- ERR:
  - err_o = 1, busy_o = 0, rx_ready_o = 0, cpu_start_o = 0.
  - No further writes. Stays in ERR until reset.
- Writes are never issued outside PAYLOAD and FILL. imem_addr_o never exceeds IMEM_DEPTH-1.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - A running XOR over all header and payload bytes is maintained.
  - In CKSUM, the accepted byte is compared against the running XOR.
  - Match -> FILL; mismatch -> ERR. Payload words already written remain in memory, but cpu_start_o is never asserted.
- Undefined:
  - The CKSUM state and the XOR register do not exist; PAYLOAD goes directly to FILL.
  - The stream carries no checksum byte.

Decomposition:
- Package imem_boot_pkg holds:
  - the state enum (HDR0, HDR1, PAYLOAD, CKSUM, FILL, DONE, ERR);
  - the header length constant (2);
  - the bytes-per-word constant (4);
  - the word-count width (16).
- Sub-module imem_boot_word_asm:
  - Byte-to-word little-endian assembler with a 2-bit byte counter.
  - Outputs word_o and a word_valid_o pulse.
  - Has a clear input driven by the top FSM.

Test Plan:
1. Stream 02 00 | 93 00 50 00 | 13 01 A0 00, no gaps:
   - Writes addr0 = 0x00500093 and addr1 = 0x00A00113.
   - Then 254 zero writes to addr 2..255.
   - Then cpu_start_o = 1 and busy_o = 0; err_o stays 0.
2. Count 00 00:
   - Exactly 256 zero writes to addr 0..255, then cpu_start_o = 1.
3. Count 01 01 (257):
   - err_o = 1 the cycle after byte 1; rx_ready_o = 0.
   - imem_we_o is never asserted and cpu_start_o stays 0.
4. Same stream as test 1 with rx_valid_i randomly deasserted 50% of cycles:
   - Identical write sequence and final memory contents as test 1; only the timing differs.
5. rst_i pulsed after 5 accepted bytes of test 1:
   - All outputs return to reset values immediately and no write is issued for the partial word.
   - A fresh full stream then reproduces the test 1 result.
6. With IMEM_BOOT_CHECKSUM_EN, stream 01 00 | 93 00 50 00:
   - Checksum byte 0xC2 -> fill proceeds, then start.
   - Checksum byte 0x00 -> err_o = 1, cpu_start_o = 0, and no FILL writes.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Checksum support is selected with the IMEM_BOOT_CHECKSUM_EN macro.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StPayload,
        StCksum,
        StFill,
        StDone,
        StErr
    } boot_state_e;

    localparam int unsigned HdrLen       = 2;
    localparam int unsigned BytesPerWord = 4;
    // The word count occupies the whole header
    localparam int unsigned CountW       = HdrLen * 8;

endpackage

// File: rtl/imem_boot_word_asm.sv
// Little-endian byte-to-word assembler; word_o/word_valid_o present the completed word
// combinationally in the cycle its final byte is accepted.
module imem_boot_word_asm
    import imem_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int unsigned CntW = $clog2(BytesPerWord);
    localparam int unsigned ShW  = 8 * (BytesPerWord - 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(BytesPerWord - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ShW-1:0]  shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + CntW'(1);
            // Newest byte enters at the top so the first byte ends up least significant
            shreg_d = {byte_i, shreg_q[ShW-1:8]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_o       = {byte_i, shreg_q};
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == LastIdx);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, zero-fills the rest and starts
// the CPU. Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              err_o
);

    // One extra bit so a count of exactly IMEM_DEPTH is representable
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0]   DepthC    = CntW'(IMEM_DEPTH);
    localparam logic [CountW-1:0] DepthHdrC = CountW'(IMEM_DEPTH);

    boot_state_e       state_q, state_d;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic              accept;
    logic [CountW-1:0] hdr_count;
    logic [CntW-1:0]   idx_inc;
    logic              asm_clear;
    logic              asm_byte_valid;
    logic [31:0]       asm_word;
    logic              asm_word_valid;

    assign rx_ready_o = (state_q == StHdr0) || (state_q == StHdr1) ||
                        (state_q == StPayload) || (state_q == StCksum);
    assign busy_o     = !((state_q == StDone) || (state_q == StErr));
    assign accept     = rx_valid_i && rx_ready_o;
    assign hdr_count  = {rx_data_i, hdr_lo_q};
    assign idx_inc    = idx_q + CntW'(1);

    assign asm_clear      = (state_q != StPayload);
    assign asm_byte_valid = accept && (state_q == StPayload);

    imem_boot_word_asm u_word_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (rx_data_i),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        hdr_lo_d = hdr_lo_q;
        count_d  = count_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        start_d  = (state_q == StDone);
`ifdef IMEM_BOOT_CHECKSUM_EN
        xor_d    = xor_q;
`endif

        case (state_q)
            StHdr0: begin
                if (accept) begin
                    hdr_lo_d = rx_data_i;
                    state_d  = StHdr1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    xor_d    = xor_q ^ rx_data_i;
`endif
                end
            end
            StHdr1: begin
                if (accept) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data_i;
`endif
                    idx_d = '0;
                    if (hdr_count > DepthHdrC) begin
                        state_d = StErr;
                    end else begin
                        count_d = hdr_count[CntW-1:0];
                        state_d = (hdr_count == '0) ? StFill : StPayload;
                    end
                end
            end
            StPayload: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (accept) begin
                    xor_d = xor_q ^ rx_data_i;
                end
`endif
                if (asm_word_valid) begin
                    we_d   = 1'b1;
                    addr_d = idx_q[ADDR_W-1:0];
                    data_d = asm_word;
                    idx_d  = idx_inc;
                    if (idx_inc == count_q) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_d = StCksum;
`else
                        state_d = (count_q == DepthC) ? StDone : StFill;
`endif
                    end
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            StCksum: begin
                if (accept) begin
                    if (rx_data_i == xor_q) begin
                        state_d = (count_q == DepthC) ? StDone : StFill;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
`endif
            StFill: begin
                // idx_q starts at N here, so addresses N..IMEM_DEPTH-1 are zeroed
                we_d   = 1'b1;
                addr_d = idx_q[ADDR_W-1:0];
                data_d = '0;
                idx_d  = idx_inc;
                if (idx_inc == DepthC) begin
                    state_d = StDone;
                end
            end
            default: begin
            end
        endcase

        err_d = err_q || (state_d == StErr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StHdr0;
            hdr_lo_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_lo_q <= hdr_lo_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_start_o = start_q;
    assign err_o       = err_q;

endmodule
